// File: rtl/fb_pkg.sv
// Shared frame-buffer definitions used by the blitter and the display-side readers.
package fb_pkg;

  localparam int unsigned FB_WIDTH  = 320;
  localparam int unsigned FB_HEIGHT = 240;
  localparam int unsigned ADDR_W    = 18;

  // One frame-buffer entry: sprite index in the upper bits, palette select in the lower bits.
  typedef struct packed {
    logic [4:0] sprite;
    logic [2:0] pltt;
  } fb_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    WRITE,
    DONE
  } blit_state_t;

endpackage

// File: rtl/blit_clip.sv
// Combinational clip of a rectangle command against the frame-buffer bounds.
module blit_clip
  import fb_pkg::*;
(
  input  logic       clear,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic [9:0] w,
  input  logic [9:0] h,
  output logic [9:0] x_start,
  output logic [9:0] y_start,
  output logic [9:0] x_end,
  output logic [9:0] y_end,
  output logic       empty
);

  localparam logic [10:0] WidthExt  = 11'(FB_WIDTH);
  localparam logic [10:0] HeightExt = 11'(FB_HEIGHT);

  logic [10:0] x_sum;
  logic [10:0] y_sum;

  // Clipped bounds; 11-bit sums so x+w / y+h cannot wrap before the min.
  always_comb begin
    x_sum = {1'b0, x} + {1'b0, w};
    y_sum = {1'b0, y} + {1'b0, h};
    if (clear) begin
      x_start = '0;
      y_start = '0;
      x_end   = 10'(FB_WIDTH);
      y_end   = 10'(FB_HEIGHT);
      empty   = 1'b0;
    end else begin
      x_start = x;
      y_start = y;
      x_end   = (x_sum > WidthExt)  ? 10'(FB_WIDTH)  : x_sum[9:0];
      y_end   = (y_sum > HeightExt) ? 10'(FB_HEIGHT) : y_sum[9:0];
      // Bounds are meaningless when empty; the FSM skips WRITE in that case.
      empty   = (w == '0) || (h == '0) || ({1'b0, x} >= WidthExt) || ({1'b0, y} >= HeightExt);
    end
  end

endmodule

// File: rtl/fb_rect_blitter.sv
// Rectangle-fill write stage: one frame-buffer entry per clock on RAM port A.
module fb_rect_blitter
  import fb_pkg::*;
(
  input  logic              clk_100MHz,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_clear,
  input  logic [9:0]        cmd_x,
  input  logic [9:0]        cmd_y,
  input  logic [9:0]        cmd_w,
  input  logic [9:0]        cmd_h,
  input  logic [7:0]        cmd_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] FB_addra,
  output logic              FB_WEA,
  output logic [7:0]        FB_dina
);

  blit_state_t state_q, state_d;

  // Command fields captured at accept.
  logic       clear_q;
  logic [9:0] x_q, y_q, w_q, h_q;
  fb_entry_t  data_q;

  // Scan state set up once in SETUP.
  logic [9:0]        col_q, x_first_q, x_end_q;
  logic [9:0]        row_q, y_end_q;
  logic [ADDR_W-1:0] row_base_q;

  logic [9:0] clip_x_start, clip_y_start, clip_x_end, clip_y_end;
  logic       clip_empty;
  logic       accept;
  logic       col_last, row_last;

  assign accept   = cmd_valid && cmd_ready;
  assign col_last = (col_q + 10'd1) == x_end_q;
  assign row_last = (row_q + 10'd1) == y_end_q;

  blit_clip u_clip (
    .clear   (clear_q),
    .x       (x_q),
    .y       (y_q),
    .w       (w_q),
    .h       (h_q),
    .x_start (clip_x_start),
    .y_start (clip_y_start),
    .x_end   (clip_x_end),
    .y_end   (clip_y_end),
    .empty   (clip_empty)
  );

  // FSM state register.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = SETUP;
      SETUP:   state_d = clip_empty ? DONE : WRITE;
      WRITE:   if (col_last && row_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Command capture and row-major scan counters.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      clear_q    <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      w_q        <= '0;
      h_q        <= '0;
      data_q     <= '0;
      col_q      <= '0;
      x_first_q  <= '0;
      x_end_q    <= '0;
      row_q      <= '0;
      y_end_q    <= '0;
      row_base_q <= '0;
    end else begin
      if (accept) begin
        clear_q <= cmd_clear;
        x_q     <= cmd_x;
        y_q     <= cmd_y;
        w_q     <= cmd_w;
        h_q     <= cmd_h;
        data_q  <= fb_entry_t'(cmd_data);
      end
      if (state_q == SETUP) begin
        col_q      <= clip_x_start;
        x_first_q  <= clip_x_start;
        x_end_q    <= clip_x_end;
        row_q      <= clip_y_start;
        y_end_q    <= clip_y_end;
        // Only multiply in the block; rows afterwards advance by addition.
        row_base_q <= ADDR_W'(clip_y_start) * ADDR_W'(FB_WIDTH);
      end
      if (state_q == WRITE) begin
        if (col_last) begin
          col_q      <= x_first_q;
          row_q      <= row_q + 10'd1;
          row_base_q <= row_base_q + ADDR_W'(FB_WIDTH);
        end else begin
          col_q <= col_q + 10'd1;
        end
      end
    end
  end

  // FSM outputs; decoded from state so reset clears them immediately.
  always_comb begin
    cmd_ready = (state_q == IDLE);
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
    FB_WEA    = (state_q == WRITE);
    FB_addra  = FB_WEA ? (row_base_q + ADDR_W'(col_q)) : '0;
    FB_dina   = FB_WEA ? data_q : '0;
  end

endmodule

// File: tb/tb_fb_rect_blitter.sv
// Randomized bench for fb_rect_blitter against a loop-based rectangle model.
module tb_fb_rect_blitter;

  localparam int Width  = 320;
  localparam int Height = 240;

  logic        clk_100MHz = 1'b0;
  logic        reset      = 1'b1;
  logic        cmd_valid  = 1'b0;
  logic        cmd_ready;
  logic        cmd_clear  = 1'b0;
  logic [9:0]  cmd_x      = '0;
  logic [9:0]  cmd_y      = '0;
  logic [9:0]  cmd_w      = '0;
  logic [9:0]  cmd_h      = '0;
  logic [7:0]  cmd_data   = '0;
  logic        busy;
  logic        done;
  logic [17:0] FB_addra;
  logic        FB_WEA;
  logic [7:0]  FB_dina;

  int checks = 0;
  int errors = 0;
  int exp_addr[$];

  fb_rect_blitter dut (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_clear  (cmd_clear),
    .cmd_x      (cmd_x),
    .cmd_y      (cmd_y),
    .cmd_w      (cmd_w),
    .cmd_h      (cmd_h),
    .cmd_data   (cmd_data),
    .busy       (busy),
    .done       (done),
    .FB_addra   (FB_addra),
    .FB_WEA     (FB_WEA),
    .FB_dina    (FB_dina)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Expected write addresses in row-major order for one command.
  task automatic model(input bit clr, input int x, input int y, input int w, input int h);
    int x0, y0, xe, ye;
    exp_addr.delete();
    if (clr) begin
      x0 = 0; y0 = 0; xe = Width; ye = Height;
    end else begin
      if (w == 0 || h == 0 || x >= Width || y >= Height) return;
      x0 = x; y0 = y; xe = imin(x + w, Width); ye = imin(y + h, Height);
    end
    for (int r = y0; r < ye; r++)
      for (int c = x0; c < xe; c++)
        exp_addr.push_back(r * Width + c);
  endtask

  task automatic scramble();
    cmd_clear = 1'($urandom_range(0, 1));
    cmd_x     = 10'($urandom);
    cmd_y     = 10'($urandom);
    cmd_w     = 10'($urandom);
    cmd_h     = 10'($urandom);
    cmd_data  = 8'($urandom);
  endtask

  // Wait (bounded) for cmd_ready, then let the accepting edge pass.
  task automatic accept();
    int t = 0;
    while (!cmd_ready && t < 200) begin
      @(negedge clk_100MHz);
      t++;
    end
    check("ready_before_accept", 64'(cmd_ready), 64'd1);
    @(posedge clk_100MHz);
    #1;
  endtask

  task automatic start_cmd(input bit clr, input int x, input int y, input int w, input int h,
                           input logic [7:0] d, input bit hold);
    @(negedge clk_100MHz);
    cmd_clear = clr;
    cmd_x     = 10'(x);
    cmd_y     = 10'(y);
    cmd_w     = 10'(w);
    cmd_h     = 10'(h);
    cmd_data  = d;
    cmd_valid = 1'b1;
    model(clr, x, y, w, h);
    accept();
    if (!hold) begin
      cmd_valid = 1'b0;
      scramble();
    end
  endtask

  // Follow one accepted command to its done pulse, checking every write.
  task automatic track(input string tag, input logic [7:0] d);
    int n        = exp_addr.size();
    int cyc      = 0;
    int nwr      = 0;
    int first_wr = -1;
    int done_cyc = -1;
    int cmd_errs = 0;
    bit ready_hi = 1'b0;
    bit busy_lo  = 1'b0;
    int e0;
    while (done_cyc < 0 && cyc < n + 20) begin
      @(negedge clk_100MHz);
      cyc++;
      if (cmd_ready) ready_hi = 1'b1;
      if (!busy) busy_lo = 1'b1;
      if (FB_WEA) begin
        if (first_wr < 0) first_wr = cyc;
        if (nwr < n && cmd_errs < 4) begin
          e0 = errors;
          check({tag, "_wr_addr_data"}, 64'({FB_addra, FB_dina}),
                64'({18'(exp_addr[nwr]), d}));
          if (errors != e0) cmd_errs++;
        end
        nwr++;
      end
      if (done) done_cyc = cyc;
    end
    check({tag, "_done_cycle"}, 64'(done_cyc), 64'(n + 2));
    check({tag, "_write_count"}, 64'(nwr), 64'(n));
    if (n > 0) check({tag, "_first_write_cycle"}, 64'(first_wr), 64'd2);
    check({tag, "_ready_low_while_busy"}, 64'(ready_hi), 64'd0);
    check({tag, "_busy_held"}, 64'(busy_lo), 64'd0);
  endtask

  task automatic expect_idle(input string tag);
    @(negedge clk_100MHz);
    check({tag, "_idle_ready"}, 64'(cmd_ready), 64'd1);
    check({tag, "_idle_busy"}, 64'(busy), 64'd0);
    check({tag, "_idle_wea"}, 64'(FB_WEA), 64'd0);
  endtask

  initial begin
    int wr_after_rst;
    logic [7:0] d1, d2;

    // Reset state.
    #12;
    check("rst_ready", 64'(cmd_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_wea", 64'(FB_WEA), 64'd0);
    check("rst_addr", 64'(FB_addra), 64'd0);
    check("rst_dina", 64'(FB_dina), 64'd0);
    @(negedge clk_100MHz);
    reset = 1'b0;

    // Directed cases.
    start_cmd(1'b0, 10, 5, 3, 2, 8'h1A, 1'b0);
    check("small_exp_first", 64'(exp_addr[0]), 64'd1610);
    track("small", 8'h1A);
    expect_idle("small");

    start_cmd(1'b0, 318, 239, 4, 3, 8'hC5, 1'b0);
    track("clip", 8'hC5);

    start_cmd(1'b0, 20, 20, 0, 5, 8'h77, 1'b0);
    track("w0", 8'h77);
    expect_idle("w0");

    start_cmd(1'b0, 400, 20, 5, 5, 8'h33, 1'b0);
    track("x400", 8'h33);
    expect_idle("x400");

    start_cmd(1'b1, 100, 100, 1, 1, 8'h00, 1'b0);
    track("clear", 8'h00);

    // Back-to-back with cmd_valid held; second command's fields appear mid-command.
    d1 = 8'($urandom);
    d2 = 8'($urandom);
    start_cmd(1'b0, 300, 100, 30, 3, d1, 1'b1);
    cmd_clear = 1'b0;
    cmd_x     = 10'd5;
    cmd_y     = 10'd200;
    cmd_w     = 10'd4;
    cmd_h     = 10'd2;
    cmd_data  = d2;
    track("b2b_first", d1);
    model(1'b0, 5, 200, 4, 2);
    @(negedge clk_100MHz);
    check("b2b_ready_after_done", 64'(cmd_ready), 64'd1);
    @(posedge clk_100MHz);
    #1;
    cmd_valid = 1'b0;
    scramble();
    track("b2b_second", d2);

    // Reset during WRITE of a 10x10 fill.
    start_cmd(1'b0, 50, 60, 10, 10, 8'h5A, 1'b0);
    repeat (17) @(negedge clk_100MHz);
    check("pre_rst_wea", 64'(FB_WEA), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_wea", 64'(FB_WEA), 64'd0);
    check("async_rst_ready", 64'(cmd_ready), 64'd1);
    check("async_rst_busy", 64'(busy), 64'd0);
    check("async_rst_done", 64'(done), 64'd0);
    wr_after_rst = 0;
    repeat (3) begin
      @(negedge clk_100MHz);
      if (FB_WEA) wr_after_rst++;
    end
    check("writes_in_reset", 64'(wr_after_rst), 64'd0);
    reset = 1'b0;
    start_cmd(1'b0, 7, 9, 5, 4, 8'hE1, 1'b0);
    track("post_rst", 8'hE1);

    // Randomized commands, biased toward the right/bottom edges to exercise clipping.
    for (int i = 0; i < 16; i++) begin
      int rx, ry, rw, rh;
      rx = (i % 2 == 0) ? $urandom_range(0, 339) : $urandom_range(290, 330);
      ry = (i % 3 == 0) ? $urandom_range(225, 250) : $urandom_range(0, 259);
      rw = $urandom_range(0, 24);
      rh = $urandom_range(0, 10);
      d1 = 8'($urandom);
      start_cmd(1'b0, rx, ry, rw, rh, d1, 1'b0);
      track("rand", d1);
    end
    expect_idle("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
